dual_port_ram_be_clr: RTL and testbench

//  Parametrised simple-dual-port synchronous RAM (one write port, one read port, one clock) with byte-lane

---
 rtl/dual_port_ram_be_clr.sv | 172 +++++++++++++++++
 tb/tb_dual_port_ram_be_clr.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_be_clr.sv
// rtl/dual_port_ram_be_clr.sv - simple-dual-port RAM with byte-lane writes, 1/2-cycle reads and background clear
// The clear engine owns the write port while clr_busy is high; user reads and writes are dropped then.
module dual_port_ram_be_clr #(
  parameter int                  DATA_W   = 32,
  parameter int                  BYTE_W   = 8,
  parameter int                  ADDR_W   = 10,
  parameter int                  DEPTH    = 1024,
  parameter int                  RD_LAT   = 1,
  parameter int                  RDW_MODE = 0,
  parameter logic [DATA_W-1:0]   CLR_VAL  = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_start,
  output logic                       clr_busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W/BYTE_W-1:0]   wr_be,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid
);

  localparam int                NB        = DATA_W / BYTE_W;
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  if (DATA_W % BYTE_W != 0) begin : g_chk_be
    $error("DATA_W must be a multiple of BYTE_W");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_chk_lat
    $error("RD_LAT must be 1 or 2");
  end
  if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_chk_depth
    $error("DEPTH must be in 1..2**ADDR_W");
  end

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr_ok;
  logic                rd_ok;
  logic                rd_in_range;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [NB-1:0]       mem_wbe;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   rd_word;

  logic                s1_valid_q;
  logic [DATA_W-1:0]   s1_data_q;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_addr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  assign clr_busy    = (state_q == ST_CLEAR);
  assign wr_ok       = !clr_busy && wr_en && ({1'b0, wr_addr} < DEPTH_X);
  assign rd_ok       = !clr_busy && rd_en;
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);

  // Single physical write port shared between the clear engine and the user.
  always_comb begin
    mem_we    = wr_ok;
    mem_waddr = wr_addr;
    mem_wbe   = wr_be;
    mem_wdata = wr_data;
    if (clr_busy) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr_q;
      mem_wbe   = '1;
      mem_wdata = CLR_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_wbe[i]) begin
          mem[mem_waddr][i*BYTE_W +: BYTE_W] <= mem_wdata[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Write-first mode forwards the enabled lanes of a colliding write into the read result.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[rd_addr];
      if (RDW_MODE == 1 && wr_ok && wr_addr == rd_addr) begin
        for (int i = 0; i < NB; i++) begin
          if (wr_be[i]) begin
            rd_word[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_ok;
      if (rd_ok) begin
        s1_data_q <= rd_word;
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              s2_valid_q;
    logic [DATA_W-1:0] s2_data_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign rd_valid = s2_valid_q;
    assign rd_data  = s2_data_q;
  end else begin : g_lat1
    assign rd_valid = s1_valid_q;
    assign rd_data  = s1_data_q;
  end

endmodule

// File: tb/tb_dual_port_ram_be_clr.sv
// tb/tb_dual_port_ram_be_clr.sv - directed vector bench for dual_port_ram_be_clr
// Three instances share stimulus: read-first/latency 1, write-first/latency 1 with nonzero clear value, latency 2.
module tb_dual_port_ram_be_clr;

  logic        clk;
  logic        rst;
  logic        clr_start;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [9:0]  rd_addr;

  logic        a_busy, b_busy, c_busy;
  logic [31:0] a_data, b_data, c_data;
  logic        a_valid, b_valid, c_valid;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] B_CLR = 32'hA5A5_5A5A;

  dual_port_ram_be_clr #(.RD_LAT(1), .RDW_MODE(0), .CLR_VAL(32'h0)) u_a (
    .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(a_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_data), .rd_valid(a_valid)
  );

  dual_port_ram_be_clr #(.RD_LAT(1), .RDW_MODE(1), .CLR_VAL(B_CLR)) u_b (
    .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(b_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_data), .rd_valid(b_valid)
  );

  dual_port_ram_be_clr #(.RD_LAT(2), .RDW_MODE(0), .CLR_VAL(32'h0)) u_c (
    .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(c_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(c_data), .rd_valid(c_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic        exp_valid;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr_start = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_be     = '0;
    wr_data   = '0;
    rd_en     = 1'b0;
    rd_addr   = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (a_busy && n < 3000) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    int stray;

    // wr_en addr be data | rd_en addr | valid exp_a exp_b
    vecs[0]  = '{1'b0, 10'd0,    4'h0, 32'h0,        1'b1, 10'd0,    1'b1, 32'h0,        B_CLR};
    vecs[1]  = '{1'b0, 10'd0,    4'h0, 32'h0,        1'b1, 10'd513,  1'b1, 32'h0,        B_CLR};
    vecs[2]  = '{1'b0, 10'd0,    4'h0, 32'h0,        1'b1, 10'd1023, 1'b1, 32'h0,        B_CLR};
    vecs[3]  = '{1'b0, 10'd0,    4'h0, 32'h0,        1'b0, 10'd0,    1'b0, 32'h0,        B_CLR};
    vecs[4]  = '{1'b1, 10'd5,    4'hF, 32'hAABBCCDD, 1'b0, 10'd0,    1'b0, 32'h0,        B_CLR};
    vecs[5]  = '{1'b1, 10'd5,    4'h5, 32'h11223344, 1'b0, 10'd0,    1'b0, 32'h0,        B_CLR};
    vecs[6]  = '{1'b0, 10'd0,    4'h0, 32'h0,        1'b1, 10'd5,    1'b1, 32'hAA22CC44, 32'hAA22CC44};
    vecs[7]  = '{1'b1, 10'd7,    4'hF, 32'hDEADBEEF, 1'b0, 10'd0,    1'b0, 32'hAA22CC44, 32'hAA22CC44};
    vecs[8]  = '{1'b1, 10'd7,    4'hF, 32'h12345678, 1'b1, 10'd7,    1'b1, 32'hDEADBEEF, 32'h12345678};
    vecs[9]  = '{1'b0, 10'd0,    4'h0, 32'h0,        1'b1, 10'd7,    1'b1, 32'h12345678, 32'h12345678};
    vecs[10] = '{1'b1, 10'd7,    4'h0, 32'hFFFFFFFF, 1'b1, 10'd7,    1'b1, 32'h12345678, 32'h12345678};
    vecs[11] = '{1'b0, 10'd0,    4'h0, 32'h0,        1'b1, 10'd7,    1'b1, 32'h12345678, 32'h12345678};
    vecs[12] = '{1'b1, 10'd1023, 4'h8, 32'hCAFEF00D, 1'b1, 10'd1023, 1'b1, 32'h0,        32'hCAA55A5A};
    vecs[13] = '{1'b0, 10'd0,    4'h0, 32'h0,        1'b1, 10'd1023, 1'b1, 32'hCA000000, 32'hCAA55A5A};
    vecs[14] = '{1'b0, 10'd0,    4'h0, 32'h0,        1'b0, 10'd0,    1'b0, 32'hCA000000, 32'hCAA55A5A};

    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy", {31'd0, a_busy}, 32'd1);
    chk("rst_valid_a", {31'd0, a_valid}, 32'd0);
    chk("rst_data_a", a_data, 32'h0);
    chk("rst_valid_c", {31'd0, c_valid}, 32'd0);
    chk("rst_data_c", c_data, 32'h0);
    count_busy(n);
    chk("rst_clear_cycles", n, 32'd1024);
    chk("b_busy_done", {31'd0, b_busy}, 32'd0);
    chk("c_busy_done", {31'd0, c_busy}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      idle();
      wr_en   = vecs[i].wr_en;
      wr_addr = vecs[i].wr_addr;
      wr_be   = vecs[i].wr_be;
      wr_data = vecs[i].wr_data;
      rd_en   = vecs[i].rd_en;
      rd_addr = vecs[i].rd_addr;
      tick();
      chk($sformatf("v%0d_valid_a", i), {31'd0, a_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("v%0d_valid_b", i), {31'd0, b_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("v%0d_data_a", i), a_data, vecs[i].exp_a);
      chk($sformatf("v%0d_data_b", i), b_data, vecs[i].exp_b);
    end

    // Latency-2 back-to-back reads
    for (int i = 0; i < 4; i++) begin
      idle();
      wr_en   = 1'b1;
      wr_addr = 10'(i);
      wr_be   = 4'hF;
      wr_data = 32'h100 + i;
      tick();
    end
    for (int j = 0; j < 6; j++) begin
      idle();
      if (j < 4) begin
        rd_en   = 1'b1;
        rd_addr = 10'(j);
      end
      tick();
      chk($sformatf("lat2_valid_c%0d", j), {31'd0, c_valid}, {31'd0, (j >= 1 && j <= 4)});
      if (j >= 1 && j <= 4) chk($sformatf("lat2_data_c%0d", j), c_data, 32'h100 + j - 1);
      chk($sformatf("lat1_valid_a%0d", j), {31'd0, a_valid}, {31'd0, (j <= 3)});
      if (j <= 3) chk($sformatf("lat1_data_a%0d", j), a_data, 32'h100 + j);
    end
    chk("lat2_hold_c", c_data, 32'h103);

    // clr_start from IDLE with a read issued in the same cycle
    idle();
    clr_start = 1'b1;
    rd_en     = 1'b1;
    rd_addr   = 10'd5;
    tick();
    chk("clr_entry_busy", {31'd0, a_busy}, 32'd1);
    chk("clr_entry_valid_a", {31'd0, a_valid}, 32'd1);
    chk("clr_entry_data_a", a_data, 32'hAA22CC44);
    n = 1;
    stray = 0;
    while (a_busy && n < 3000) begin
      idle();
      if (n == 300) begin
        wr_en   = 1'b1;
        wr_addr = 10'd9;
        wr_be   = 4'hF;
        wr_data = 32'h99999999;
        rd_en   = 1'b1;
        rd_addr = 10'd9;
      end
      if (n == 600) clr_start = 1'b1;
      tick();
      if (a_valid || b_valid) stray++;
      if (a_busy) n++;
    end
    chk("clr_cycles", n, 32'd1024);
    chk("clr_stray_valid", stray, 32'd0);
    idle();
    rd_en   = 1'b1;
    rd_addr = 10'd9;
    tick();
    chk("clr_rd9_valid_a", {31'd0, a_valid}, 32'd1);
    chk("clr_rd9_data_a", a_data, 32'h0);
    chk("clr_rd9_data_b", b_data, B_CLR);
    idle();
    rd_en   = 1'b1;
    rd_addr = 10'd5;
    tick();
    chk("clr_rd5_data_a", a_data, 32'h0);
    chk("clr_rd5_data_b", b_data, B_CLR);

    // Reset discards an in-flight latency-2 read
    idle();
    rd_en   = 1'b1;
    rd_addr = 10'd9;
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_flush_valid_c", {31'd0, c_valid}, 32'd0);
    chk("rst_flush_valid_a", {31'd0, a_valid}, 32'd0);
    chk("rst_flush_data_b", b_data, 32'h0);
    chk("rst_flush_busy", {31'd0, a_busy}, 32'd1);

    // Reset 300 cycles into a clear restarts the full walk
    n = 1;
    while (n < 300) begin
      tick();
      n++;
    end
    chk("mid_clear_busy", {31'd0, a_busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid_a", {31'd0, a_valid}, 32'd0);
    count_busy(n);
    chk("mid_rst_clear_cycles", n, 32'd1024);
    idle();
    rd_en   = 1'b1;
    rd_addr = 10'd1023;
    tick();
    chk("final_rd_valid_a", {31'd0, a_valid}, 32'd1);
    chk("final_rd_data_a", a_data, 32'h0);
    chk("final_rd_data_b", b_data, B_CLR);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
